// File: rtl/da_accum_pipe_pkg.sv
// Shared DA helpers: width derivation, pipeline tag type, and the
// round/saturate step common to the DA block family.
package da_pkg;

  localparam int unsigned DA_MAXW = 64;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } da_tag_t;

  typedef struct packed {
    logic signed [DA_MAXW-1:0] val;
    logic                      sat;
  } da_rs_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Tree output width: one bit of growth per pairwise reduction level.
  function automatic int unsigned tw(input int unsigned lw, input int unsigned nblk);
    return lw + clog2(nblk);
  endfunction

  // Accumulator width: tree width plus one bit per accumulated slice.
  function automatic int unsigned aw(input int unsigned lw, input int unsigned nblk,
                                     input int unsigned b);
    return tw(lw, nblk) + b;
  endfunction

  // Round-half-up right shift followed by clipping to a signed ow-bit range.
  // Operands up to 63 bits are exact here, so acc + half never wraps.
  function automatic da_rs_t round_sat(input logic signed [DA_MAXW-1:0] acc,
                                       input int unsigned oshift,
                                       input int unsigned ow);
    da_rs_t                    res;
    logic signed [DA_MAXW-1:0] r;
    logic signed [DA_MAXW-1:0] hi;
    logic signed [DA_MAXW-1:0] lo;
    r = acc;
    if (oshift != 0) r = (acc + (64'sd1 <<< (oshift - 1))) >>> oshift;
    hi      = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (ow - 1));
    res.val = r;
    res.sat = 1'b0;
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/da_accum_pipe_if.sv
// Slice input and result output bundle of the DA accumulation engine.
interface da_accum_pipe_if #(
  parameter int unsigned NBLK = 8,
  parameter int unsigned LW   = 20,
  parameter int unsigned OW   = 24
);
  logic                 in_valid;
  logic [NBLK*LW-1:0]   lut_q;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_sat;

  modport master (
    output in_valid, lut_q, out_ready,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, lut_q, out_ready,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/da_accum_pipe_adder_tree.sv
// Pipelined pairwise reduction of NBLK signed LUT words, one register
// level per tree level, with a valid/first/last tag pipe alongside.
module da_adder_tree
  import da_pkg::*;
#(
  parameter int unsigned NBLK = 8,
  parameter int unsigned LW   = 20,
  localparam int unsigned S   = clog2(NBLK),
  localparam int unsigned TW  = LW + S
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [NBLK*LW-1:0]   lut_q,
  output logic                 out_valid,
  output logic                 out_first,
  output logic                 out_last,
  output logic signed [TW-1:0] out_sum
);

  da_tag_t tag_d [S];
  da_tag_t tag_q [S];

  // Tag pipe advances every cycle; clr drops everything in flight.
  always_comb begin
    tag_d[0] = '{vld: in_valid, first: in_first, last: in_last};
    for (int unsigned i = 1; i < S; i++) tag_d[i] = tag_q[i-1];
    if (clr) begin
      for (int unsigned i = 0; i < S; i++) tag_d[i] = '0;
    end
  end

  // Tag registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < S; i++) tag_q[i] <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_stg
    localparam int unsigned N = NBLK >> (s + 1);
    localparam int unsigned W = LW + s + 1;

    logic signed [W-1:0] sum_d [N];
    logic signed [W-1:0] sum_q [N];

    if (s == 0) begin : g_leaf
      // First level: pair up raw LUT banks, sign-extended by one bit.
      always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
          sum_d[j] = W'(signed'(lut_q[2*j*LW +: LW]))
                   + W'(signed'(lut_q[(2*j+1)*LW +: LW]));
        end
      end
    end else begin : g_node
      // Inner levels: pair up the previous level's registered sums.
      always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
          sum_d[j] = W'(g_stg[s-1].sum_q[2*j]) + W'(g_stg[s-1].sum_q[2*j+1]);
        end
      end
    end

    // Data registers carry no reset; only the tags qualify them.
    always_ff @(posedge clk) begin
      sum_q <= sum_d;
    end
  end

  assign out_sum   = g_stg[S-1].sum_q[0];
  assign out_valid = tag_q[S-1].vld;
  assign out_first = tag_q[S-1].first;
  assign out_last  = tag_q[S-1].last;

endmodule

// File: rtl/da_accum_pipe.sv
// DA accumulation engine: slice counter, adder tree, MSB-first
// shift-accumulator, round/saturate stage and valid/ready result port.
module da_accum_pipe
  import da_pkg::*;
#(
  parameter int unsigned NBLK      = 8,
  parameter int unsigned LW        = 20,
  parameter int unsigned B         = 16,
  parameter bit          SIGNED_IN = 1'b1,
  parameter int unsigned OW        = 24,
  parameter int unsigned OSHIFT    = 0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clr,
  da_accum_pipe_if.slave  bus,
  output logic            ovr_err
);

  localparam int unsigned TW = tw(LW, NBLK);
  localparam int unsigned AW = aw(LW, NBLK, B);
  localparam int unsigned CW = (B > 1) ? clog2(B) : 1;

  logic [CW-1:0]        cnt_d, cnt_q;
  logic                 slice_first, slice_last;
  logic                 t_vld, t_first, t_last;
  logic signed [TW-1:0] t_sum;
  logic signed [AW-1:0] t_ext;
  logic signed [AW-1:0] acc_d, acc_q;
  logic                 done_d, done_q;
  da_rs_t               rs;
  logic                 unused_rs_hi;
  logic                 rnd_vld_d, rnd_vld_q;
  logic signed [OW-1:0] rnd_data_d, rnd_data_q;
  logic                 rnd_sat_d, rnd_sat_q;
  logic                 out_valid_d, out_valid_q;
  logic signed [OW-1:0] out_data_d, out_data_q;
  logic                 out_sat_d, out_sat_q;
  logic                 ovr_d, ovr_q;

  // Slice position within the word; clr restarts at the MSB slice.
  always_comb begin
    slice_first = (cnt_q == '0);
    slice_last  = (cnt_q == CW'(B - 1));
    cnt_d       = cnt_q;
    if (clr) cnt_d = '0;
    else if (bus.in_valid) cnt_d = slice_last ? '0 : cnt_q + CW'(1);
  end

  da_adder_tree #(
    .NBLK (NBLK),
    .LW   (LW)
  ) u_tree (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (clr),
    .in_valid  (bus.in_valid),
    .in_first  (slice_first),
    .in_last   (slice_last),
    .lut_q     (bus.lut_q),
    .out_valid (t_vld),
    .out_first (t_first),
    .out_last  (t_last),
    .out_sum   (t_sum)
  );

  // MSB-first shift-accumulate; the sign slice enters negated for signed input.
  always_comb begin
    t_ext  = AW'(t_sum);
    acc_d  = acc_q;
    done_d = 1'b0;
    if (t_vld) begin
      if (t_first) acc_d = SIGNED_IN ? -t_ext : t_ext;
      else         acc_d = (acc_q <<< 1) + t_ext;
      done_d = t_last;
    end
    if (clr) done_d = 1'b0;
  end

  // Round/saturate the finished accumulator one cycle after done.
  always_comb begin
    rs         = round_sat(64'(acc_q), OSHIFT, OW);
    rnd_vld_d  = done_q & ~clr;
    rnd_data_d = rnd_data_q;
    rnd_sat_d  = rnd_sat_q;
    if (done_q) begin
      rnd_data_d = rs.val[OW-1:0];
      rnd_sat_d  = rs.sat;
    end
  end

  // After clipping, bits above OW-1 are pure sign extension.
  assign unused_rs_hi = ^rs.val[DA_MAXW-1:OW];

  // Result register: a new result always loads; loading over a held,
  // unaccepted result raises the sticky overrun flag.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    ovr_d       = ovr_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (rnd_vld_q) begin
      out_valid_d = 1'b1;
      out_data_d  = rnd_data_q;
      out_sat_d   = rnd_sat_q;
      if (out_valid_q && !bus.out_ready) ovr_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      rnd_vld_q   <= 1'b0;
      rnd_data_q  <= '0;
      rnd_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      rnd_vld_q   <= rnd_vld_d;
      rnd_data_q  <= rnd_data_d;
      rnd_sat_q   <= rnd_sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign ovr_err       = ovr_q;

endmodule

// File: tb/tb_da_accum_pipe.sv
// Bench for da_accum_pipe: four configurations driven in lockstep and
// checked against a weighted-sum reference model.
module tb_da_accum_pipe;

  localparam int unsigned NBLK = 8;
  localparam int unsigned LW   = 20;
  localparam int unsigned B    = 16;
  localparam int unsigned ND   = 4;
  localparam int unsigned LAT  = 5;

  typedef logic [NBLK*LW-1:0] slice_t;
  typedef struct packed {
    logic signed [63:0] v;
    logic               s;
  } res_t;

  // Configurations: a signed/OW24, b unsigned/OW24, c unsigned/OW16, d signed/OSHIFT2
  bit          cfg_sgn [ND] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int unsigned cfg_ow  [ND] = '{24, 24, 16, 24};
  int unsigned cfg_os  [ND] = '{0, 0, 0, 2};

  logic   clk = 1'b0;
  logic   resetn = 1'b0;
  logic   clr = 1'b0;
  logic   in_valid = 1'b0;
  logic   out_ready = 1'b1;
  slice_t lut_q = '0;

  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  da_accum_pipe_if #(.NBLK(NBLK), .LW(LW), .OW(24)) ifa ();
  da_accum_pipe_if #(.NBLK(NBLK), .LW(LW), .OW(24)) ifb ();
  da_accum_pipe_if #(.NBLK(NBLK), .LW(LW), .OW(16)) ifc ();
  da_accum_pipe_if #(.NBLK(NBLK), .LW(LW), .OW(24)) ifd ();

  assign ifa.in_valid = in_valid;  assign ifa.lut_q = lut_q;  assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;  assign ifb.lut_q = lut_q;  assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;  assign ifc.lut_q = lut_q;  assign ifc.out_ready = out_ready;
  assign ifd.in_valid = in_valid;  assign ifd.lut_q = lut_q;  assign ifd.out_ready = out_ready;

  logic               ov   [ND];
  logic               osat [ND];
  logic               ovr  [ND];
  logic signed [63:0] od   [ND];

  assign ov[0] = ifa.out_valid;  assign osat[0] = ifa.out_sat;  assign od[0] = 64'(ifa.out_data);
  assign ov[1] = ifb.out_valid;  assign osat[1] = ifb.out_sat;  assign od[1] = 64'(ifb.out_data);
  assign ov[2] = ifc.out_valid;  assign osat[2] = ifc.out_sat;  assign od[2] = 64'(ifc.out_data);
  assign ov[3] = ifd.out_valid;  assign osat[3] = ifd.out_sat;  assign od[3] = 64'(ifd.out_data);

  da_accum_pipe #(.NBLK(NBLK), .LW(LW), .B(B), .SIGNED_IN(1'b1), .OW(24), .OSHIFT(0)) dut_a (
    .clk(clk), .resetn(resetn), .clr(clr), .bus(ifa), .ovr_err(ovr[0]));
  da_accum_pipe #(.NBLK(NBLK), .LW(LW), .B(B), .SIGNED_IN(1'b0), .OW(24), .OSHIFT(0)) dut_b (
    .clk(clk), .resetn(resetn), .clr(clr), .bus(ifb), .ovr_err(ovr[1]));
  da_accum_pipe #(.NBLK(NBLK), .LW(LW), .B(B), .SIGNED_IN(1'b0), .OW(16), .OSHIFT(0)) dut_c (
    .clk(clk), .resetn(resetn), .clr(clr), .bus(ifc), .ovr_err(ovr[2]));
  da_accum_pipe #(.NBLK(NBLK), .LW(LW), .B(B), .SIGNED_IN(1'b1), .OW(24), .OSHIFT(2)) dut_d (
    .clk(clk), .resetn(resetn), .clr(clr), .bus(ifd), .ovr_err(ovr[3]));

  // Accepted-result monitor, sampled on the falling edge.
  res_t        rq [ND][$];
  int unsigned t0 [$];

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (ov[d] && out_ready) rq[d].push_back({od[d], osat[d]});
    end
    if (ov[0] && out_ready) t0.push_back(cyc);
  end

  // ---------------- reference model ----------------
  function automatic longint model_acc(input slice_t w [B], input bit sgn);
    longint             acc, s;
    logic signed [LW-1:0] bank;
    acc = 0;
    for (int i = 0; i < B; i++) begin
      s = 0;
      for (int k = 0; k < NBLK; k++) begin
        bank = w[i][k*LW +: LW];
        s += longint'(bank);
      end
      if (sgn && i == 0) acc -= s * (longint'(1) << (B - 1));
      else               acc += s * (longint'(1) << (B - 1 - i));
    end
    return acc;
  endfunction

  function automatic res_t expect_for(input slice_t w [B], input int d);
    longint acc, r, hi, lo;
    bit     sat;
    acc = model_acc(w, cfg_sgn[d]);
    r   = acc;
    if (cfg_os[d] > 0) r = (acc + (longint'(1) << (cfg_os[d] - 1))) >>> cfg_os[d];
    hi  = (longint'(1) << (cfg_ow[d] - 1)) - 1;
    lo  = -hi - 1;
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return {r, sat};
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic slice_t rand_slice();
    return slice_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic slice_t const_slice(input logic [LW-1:0] b0, input logic [LW-1:0] rest);
    slice_t v;
    v = '0;
    for (int k = 0; k < NBLK; k++) v[k*LW +: LW] = (k == 0) ? b0 : rest;
    return v;
  endfunction

  function automatic res_t pop(input int d);
    if (rq[d].size() == 0) return 'x;
    return rq[d].pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int d = 0; d < ND; d++) rq[d].delete();
    t0.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    flush();
  endtask

  task automatic drive_slices(input slice_t w [B], input int unsigned n, input int unsigned gap_pct);
    for (int unsigned i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        lut_q    = rand_slice();
        tick();
      end
      in_valid = 1'b1;
      lut_q    = w[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int unsigned n, output bit ok);
    for (int i = 0; i < 80; i++) begin
      if (rq[0].size() >= n) break;
      tick();
    end
    ok = (rq[0].size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int d = 0; d < ND; d++) begin
      compared++;
      if ({ov[d], osat[d], ovr[d]} !== 3'b000 || od[d] !== 64'sd0) begin
        mismatched++;
        $display("FAIL reset[%0d]: got valid=%0b sat=%0b ovr=%0b data=%0d, expected all 0",
                 d, ov[d], osat[d], ovr[d], od[d]);
      end
    end
  endtask

  task automatic test_basic();
    slice_t      w [B];
    res_t        g;
    res_t        e [ND];
    int unsigned last;
    bit          ok;
    e = '{{64'(-8), 1'b0}, {64'(524280), 1'b0}, {64'(32767), 1'b1}, {64'(-2), 1'b0}};
    for (int i = 0; i < B; i++) w[i] = const_slice(20'd1, 20'd1);
    flush();
    out_ready = 1'b1;
    drive_slices(w, B, 0);
    last = cyc;
    wait_res(1, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL basic_timeout: got 0 results, expected 1");
    end else begin
      compared++;
      if (t0[0] - last !== LAT) begin
        mismatched++;
        $display("FAIL basic_latency: got %0d, expected %0d", t0[0] - last, LAT);
      end
      for (int d = 0; d < ND; d++) begin
        g = pop(d);
        compared++;
        if (g !== e[d]) begin
          mismatched++;
          $display("FAIL basic[%0d]: got %0d sat=%0b, expected %0d sat=%0b", d, g.v, g.s, e[d].v, e[d].s);
        end
      end
    end
  endtask

  task automatic test_round();
    slice_t w [B];
    res_t   g;
    res_t   e [ND];
    bit     ok;
    e = '{{64'(6), 1'b0}, {64'(6), 1'b0}, {64'(6), 1'b0}, {64'(2), 1'b0}};
    for (int i = 0; i < B; i++) w[i] = '0;
    w[B-2] = const_slice(20'd3, 20'd0);
    flush();
    drive_slices(w, B, 0);
    wait_res(1, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL round_timeout: got 0 results, expected 1");
    end else begin
      for (int d = 0; d < ND; d++) begin
        g = pop(d);
        compared++;
        if (g !== e[d]) begin
          mismatched++;
          $display("FAIL round[%0d]: got %0d sat=%0b, expected %0d sat=%0b", d, g.v, g.s, e[d].v, e[d].s);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    slice_t w1 [B];
    slice_t w2 [B];
    res_t   g, e;
    bit     ok;
    for (int i = 0; i < B; i++) begin w1[i] = rand_slice(); w2[i] = rand_slice(); end
    // Stalled consumer: second result overwrites the first.
    flush();
    out_ready = 1'b0;
    drive_slices(w1, B, 0);
    drive_slices(w2, B, 0);
    repeat (8) tick();
    for (int d = 0; d < ND; d++) begin
      e = expect_for(w2, d);
      compared++;
      if (ov[d] !== 1'b1 || ovr[d] !== 1'b1 || {od[d], osat[d]} !== e) begin
        mismatched++;
        $display("FAIL overwrite[%0d]: got valid=%0b ovr=%0b %0d sat=%0b, expected valid=1 ovr=1 %0d sat=%0b",
                 d, ov[d], ovr[d], od[d], osat[d], e.v, e.s);
      end
    end
    out_ready = 1'b1;
    repeat (2) tick();
    for (int d = 0; d < ND; d++) begin
      compared++;
      if (ov[d] !== 1'b0 || ovr[d] !== 1'b1) begin
        mismatched++;
        $display("FAIL ovr_sticky[%0d]: got valid=%0b ovr=%0b, expected valid=0 ovr=1", d, ov[d], ovr[d]);
      end
    end
    // Free-running consumer: two results, one word apart, no error.
    do_reset();
    out_ready = 1'b1;
    drive_slices(w1, B, 0);
    drive_slices(w2, B, 0);
    wait_res(2, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL b2b_timeout: got %0d results, expected 2", rq[0].size());
    end else begin
      compared++;
      if (t0[1] - t0[0] !== B) begin
        mismatched++;
        $display("FAIL b2b_spacing: got %0d, expected %0d", t0[1] - t0[0], B);
      end
      for (int d = 0; d < ND; d++) begin
        g = pop(d); e = expect_for(w1, d);
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL b2b_w1[%0d]: got %0d sat=%0b, expected %0d sat=%0b", d, g.v, g.s, e.v, e.s);
        end
        g = pop(d); e = expect_for(w2, d);
        compared++;
        if (g !== e || ovr[d] !== 1'b0) begin
          mismatched++;
          $display("FAIL b2b_w2[%0d]: got %0d sat=%0b ovr=%0b, expected %0d sat=%0b ovr=0",
                   d, g.v, g.s, ovr[d], e.v, e.s);
        end
      end
    end
  endtask

  task automatic test_gaps();
    slice_t w [B];
    res_t   g, e;
    bit     ok;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < B; i++) w[i] = rand_slice();
      flush();
      drive_slices(w, B, 30);
      wait_res(1, ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL gaps_timeout[%0d]: got 0 results, expected 1", it);
      end else begin
        for (int d = 0; d < ND; d++) begin
          g = pop(d); e = expect_for(w, d);
          compared++;
          if (g !== e) begin
            mismatched++;
            $display("FAIL gaps[%0d][%0d]: got %0d sat=%0b, expected %0d sat=%0b", it, d, g.v, g.s, e.v, e.s);
          end
        end
      end
    end
  endtask

  task automatic test_mixed();
    slice_t w [B];
    res_t   g, e;
    bit     ok;
    for (int i = 0; i < B; i++) w[i] = const_slice(20'h80000, 20'h7FFFF);
    flush();
    drive_slices(w, B, 0);
    wait_res(1, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL mixed_timeout: got 0 results, expected 1");
    end else begin
      for (int d = 0; d < ND; d++) begin
        g = pop(d); e = expect_for(w, d);
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL mixed[%0d]: got %0d sat=%0b, expected %0d sat=%0b", d, g.v, g.s, e.v, e.s);
        end
      end
    end
  endtask

  task automatic test_abort();
    slice_t wx [B];
    slice_t wy [B];
    res_t   g, e;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < B; i++) begin wx[i] = rand_slice(); wy[i] = rand_slice(); end
      flush();
      drive_slices(wx, 8, 0);
      if (pass == 0) begin
        clr = 1'b1; in_valid = 1'b1; lut_q = rand_slice();
        tick();
        clr = 1'b0; in_valid = 1'b0;
      end else begin
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
      end
      tick();
      drive_slices(wy, B, 0);
      repeat (20) tick();
      compared++;
      if (rq[0].size() !== 1) begin
        mismatched++;
        $display("FAIL abort_count[%0d]: got %0d results, expected 1", pass, rq[0].size());
      end
      for (int d = 0; d < ND; d++) begin
        g = pop(d); e = expect_for(wy, d);
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL abort[%0d][%0d]: got %0d sat=%0b, expected %0d sat=%0b", pass, d, g.v, g.s, e.v, e.s);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_back_to_back();
    test_gaps();
    test_mixed();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/da_accum_pipe.md
# da_accum_pipe

Parametrised distributed-arithmetic (DA) accumulation engine, the next generation of the fixed 8-block DA datapath. Each cycle it takes one bit-slice worth of partial-product words from NBLK coefficient LUT banks. It reduces them through a fully pipelined adder tree, then shift-accumulates slices MSB-first, with two's-complement sign-slice subtraction when the input is signed. Finished results are rounded, saturated and presented on a valid/ready output port. It sits between the LUT SRAM bank and the filter output register and replaces the serial single-adder sequencing.

## Interface
- NBLK, 8: number of LUT banks / tree inputs; power of two, ≥2
- LW, 20: LUT word width, signed
- B, 16: input sample width = slices per result
- SIGNED_IN, 1: 1 = samples are two's complement (MSB slice subtracted); 0 = unsigned
- OW, 24: output width, signed
- OSHIFT, 0: right shift applied before output, with round-half-up; 0..AW-1
- Derived: S = clog2(NBLK); TW = LW+S; AW = TW+B

- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- clr  in  1  synchronous abort of the partial word and pipeline contents
- in_valid  in  1  slice present on lut_q
- lut_q  in  NBLK*LW  LUT words, bank i at [i*LW +: LW], signed
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  OW  rounded/saturated result, signed
- out_sat  out  1  out_data was clipped (qualified by out_valid)
- ovr_err  out  1  sticky: an unaccepted result was overwritten

## Operation
- Input is always accepted; there is no in_ready. Slices of one word arrive MSB-first. Gaps (in_valid=0) between slices are allowed.
- Slice counter cnt (0..B-1) increments on each accepted slice and wraps to 0 after B-1.
  - cnt==0 tags the slice `first`.
  - cnt==B-1 tags the slice `last`.
  - B=1: every slice is both first and last.
- Adder tree: S registered stages, each stage adds pairs, with growth of 1 bit per stage via sign-extension. Valid, first and last tags travel alongside the data.
- Accumulator, on a tree output t (sign-extended to AW):
  - first: acc ← SIGNED_IN ? −t : t
  - else: acc ← (acc<<1) + t
  - wrap-free by construction (AW bits).
- On an accumulate tagged last, a done pulse is sent to the output stage.
- Output stage, on done:
  - r = OSHIFT ? (acc + 2^(OSHIFT−1)) >>> OSHIFT : acc, computed at AW+1 bits.
  - Saturate r to [−2^(OW−1), 2^(OW−1)−1]; out_sat = 1 if clipped.
  - Load out_data/out_sat and set out_valid.
- Handshake: out_valid && out_ready clears out_valid at the next edge. out_data holds while out_valid && !out_ready.
- done while out_valid && !out_ready: the new result overwrites out_data/out_sat, out_valid stays 1, and ovr_err ← 1.
- done in the same cycle as an accepted result: the new result loads with no error.
- clr:
  - Zeros cnt and all pipeline valid/tag bits.
  - Does not touch out_valid/out_data or ovr_err.
  - clr wins over a simultaneous in_valid; that slice is dropped.
- Reset values: out_valid=0, out_data=0, out_sat=0, ovr_err=0, cnt=0, acc=0, all pipeline valids=0. ovr_err is cleared only by reset.

## Timing
- Slice accepted at edge k → its tree sum reaches the accumulator at edge k+S.
- Last slice accepted at edge k → out_valid high after edge k+S+2. Default latency is 5.
- Throughput: one slice per cycle; one result per B cycles when back-to-back. The next word's first slice may directly follow the previous word's last slice.
- The output stage has no combinational path from out_ready to out_valid.
- Reset or clr mid-word: no result is produced for the aborted word. The next accepted slice is treated as first.

## Structure
- Package da_pkg: clog2 function, width derivation helpers (TW, AW), and a saturate/round function shared with the other DA blocks.
- Sub-module da_adder_tree (NBLK, LW): generate-built pipelined reduction, with the valid/first/last tag pipe. The top level holds the slice counter, accumulator, output stage and error flag.

## Test plan
- Defaults, SIGNED_IN=1, all LUT words = 1, 16 contiguous slices → tree sum 8/slice. out_data = −8 five cycles after the last slice, out_sat=0.
- SIGNED_IN=0, same stimulus, OW=16 → exact 524280 clipped to 32767, out_sat=1. With OW=24 the output is 524280, out_sat=0.
- OSHIFT=2, signed stimulus giving acc=−8 → out_data=−2; acc=6 → 2 (round half up).
- Two back-to-back words with out_ready=0 → second result overwrites the first, ovr_err=1 and stays 1 after out_ready. With out_ready=1 → two results 16 cycles apart, ovr_err=0.
- Random in_valid gaps inside a word vs the contiguous reference → identical out_data. Mixed-sign LUT words (bank0=−524288, others=524287) checked against a golden model over B slices.
- clr asserted after slice 7 with in_valid=1, then a full new word → exactly one result, equal to the new word only. Repeat the same check with resetn pulsed mid-word.
